apb4_regbank_slave: RTL and testbench

Parametrised APB4 completer that supersedes the fixed single-mode APB3 memory slave.
- Adds byte write strobes (pstrb) and a programmable number of wait states.
- Reports address-range, misalignment and read-only-region errors on pslverr.
- Sits behind an APB interconnect as a generic register bank or scratch memory; one instance per peripheral slot.

---
 rtl/apb4_pkg.sv | 26 ++
 rtl/apb4_err_decode.sv | 38 +++
 rtl/apb4_regbank_slave.sv | 107 ++++++++++
 tb/tb_apb4_regbank_slave.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/apb4_pkg.sv
// Shared types and helpers for APB4 completers: FSM states, bus geometry and
// byte-address to word-index conversion.
package apb4_pkg;

    typedef enum logic {IDLE, ACCESS} apb4_state_e;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_STRB_WIDTH  = DEF_DATA_WIDTH / BYTE_W;
    localparam int unsigned DEF_OFFS_WIDTH  = $clog2(DEF_STRB_WIDTH);

    function automatic int unsigned strb_width(input int unsigned dw);
        return dw / BYTE_W;
    endfunction

    function automatic int unsigned offs_width(input int unsigned dw);
        return $clog2(dw / BYTE_W);
    endfunction

    function automatic int unsigned word_index(input logic [63:0] addr, input int unsigned offs);
        logic [63:0] s;
        s = addr >> offs;
        return s[31:0];
    endfunction

endpackage

// File: rtl/apb4_err_decode.sv
// Combinational error checks on a latched APB4 address: byte misalignment,
// word index beyond the implemented depth, and writes into the read-only region.
module apb4_err_decode
    import apb4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned RO_WORDS   = 0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write,
    output logic                  misaligned,
    output logic                  out_of_range,
    output logic                  ro_violation
);

    localparam int unsigned OFFS_W = offs_width(DATA_WIDTH);

    int unsigned idx;

    assign idx          = word_index(64'(addr), OFFS_W);
    assign out_of_range = (idx >= DEPTH);

    // Degenerate parameter values would produce empty slices / vacuous compares.
    if (OFFS_W > 0) begin : g_align
        assign misaligned = (addr[OFFS_W-1:0] != '0);
    end else begin : g_no_align
        assign misaligned = 1'b0;
    end

    if (RO_WORDS > 0) begin : g_ro
        assign ro_violation = write && (idx < RO_WORDS);
    end else begin : g_no_ro
        assign ro_violation = 1'b0;
    end

endmodule

// File: rtl/apb4_regbank_slave.sv
// APB4 register bank / scratch memory with byte strobes, programmable wait
// states and error responses for range, alignment and read-only violations.
module apb4_regbank_slave
    import apb4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned RO_WORDS    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int unsigned STRB_W = strb_width(DATA_WIDTH);
    localparam int unsigned OFFS_W = offs_width(DATA_WIDTH);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb4_state_e             state, state_nx;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic                    lat_write;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [STRB_W-1:0]       lat_strb;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]        widx;
    logic                    misaligned, out_of_range, ro_violation, err;
    logic                    commit;

    assign widx = IDX_W'(lat_addr >> OFFS_W);
    assign err  = misaligned || out_of_range || ro_violation;

    apb4_err_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .RO_WORDS   (RO_WORDS)
    ) u_err_decode (
        .addr         (lat_addr),
        .write        (lat_write),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .ro_violation (ro_violation)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (psel && !penable) state_nx = ACCESS;
            ACCESS:  if (!psel || (pready && penable)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pready  = (state == ACCESS) && (cnt == 4'(WAIT_STATES));
        pslverr = pready && err;
        prdata  = (pready && !lat_write && !err) ? mem[widx] : '0;
    end

    assign commit = pready && psel && penable && lat_write && !err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (state == IDLE) begin
                if (psel && !penable) begin
                    lat_addr  <= paddr;
                    lat_write <= pwrite;
                    lat_wdata <= pwdata;
                    lat_strb  <= pstrb;
                    cnt       <= '0;
                end
            end else begin
                if (psel && (cnt != 4'(WAIT_STATES))) cnt <= cnt + 4'd1;
                if (commit) begin
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (lat_strb[b]) mem[widx][8*b +: 8] <= lat_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb4_regbank_slave.sv
// Scoreboard bench for apb4_regbank_slave: a driver issues APB4 transfers and
// queues the expected response from a word-array model; a monitor checks each pready.
module tb_apb4_regbank_slave;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned NW = 16;
    localparam int unsigned WS = 2;
    localparam int unsigned RO = 2;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        string         name;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            psel, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [DW-1:0]   prdata;
    logic            pready, pslverr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [NW];
    exp_t          exp_q[$];
    exp_t          mon_e;

    apb4_regbank_slave #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH       (NW),
        .WAIT_STATES (WS),
        .RO_WORDS    (RO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && pready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pready: got pready=1 expected no response (addr 0x%0h)", paddr);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_pslverr"}, 64'(pslverr), 64'(mon_e.err));
                check({mon_e.name, "_prdata"}, 64'(prdata), 64'(mon_e.rdata));
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < NW; i++) model[i] = '0;
    endtask

    // Called just after a rising edge; returns just after the completion edge.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [DW/8-1:0] strb, input string name);
        exp_t        e;
        int unsigned idx;
        logic        bad;
        int          cyc;
        idx = int'(addr) / (DW/8);
        bad = (int'(addr) % (DW/8) != 0) || (idx >= NW) || (wr && idx < RO);
        e.err   = bad;
        e.name  = name;
        e.rdata = (wr || bad) ? '0 : model[idx];
        if (wr && !bad)
            for (int b = 0; b < DW/8; b++)
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        exp_q.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!pready && cyc < 20);
        check({name, "_latency"}, 64'(cyc), 64'(WS + 1));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pready", 64'(pready), 64'd0);
        check("reset_pslverr", 64'(pslverr), 64'd0);
        check("reset_prdata", 64'(prdata), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // penable without setup must be ignored
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h10;
        repeat (3) begin
            @(negedge clk);
            check("no_setup_pready", 64'(pready), 64'd0);
        end
        @(posedge clk); #1;
        idle(1);

        // 1: full write then read
        xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, "t1_wr");
        xfer(1'b0, 8'h10, 32'h0, 4'h0, "t1_rd");
        // 2: partial strobes
        xfer(1'b1, 8'h10, 32'h11223344, 4'b0101, "t2_wr");
        xfer(1'b0, 8'h10, 32'h0, 4'h0, "t2_rd");
        check("t2_model", 64'(model[4]), 64'h00000000DE22BE44);
        // 3: out of range
        xfer(1'b1, 8'h40, 32'hCAFEF00D, 4'hF, "t3_wr");
        xfer(1'b0, 8'h40, 32'h0, 4'h0, "t3_rd");
        xfer(1'b0, 8'h10, 32'h0, 4'h0, "t3_rd10");
        // 4: read-only and misaligned
        xfer(1'b1, 8'h04, 32'hFFFFFFFF, 4'hF, "t4_ro");
        xfer(1'b1, 8'h13, 32'hFFFFFFFF, 4'hF, "t4_mis");
        xfer(1'b0, 8'h04, 32'h0, 4'h0, "t4_rd");
        xfer(1'b0, 8'h10, 32'h0, 4'h0, "t4_rd10");
        // zero strobe write is an OKAY no-op
        xfer(1'b1, 8'h10, 32'h55555555, 4'h0, "nostrb_wr");
        xfer(1'b0, 8'h10, 32'h0, 4'h0, "nostrb_rd");
        idle(1);

        // 5: aborted write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("t5_abort_pready", 64'(pready), 64'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("t5_abort_idle_pready", 64'(pready), 64'd0);
        @(posedge clk); #1;
        xfer(1'b0, 8'h20, 32'h0, 4'h0, "t5_rd");
        idle(1);

        // 6: reset during the second access cycle of a write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t6_rst_pready", 64'(pready), 64'd0);
        check("t6_rst_pslverr", 64'(pslverr), 64'd0);
        check("t6_rst_prdata", 64'(prdata), 64'd0);
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 8'h08, 32'h0, 4'h0, "t6_rd08");
        xfer(1'b0, 8'h10, 32'h0, 4'h0, "t6_rd10");

        // random back-to-back traffic with occasional idle gaps
        for (int n = 0; n < 80; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 71));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rnd");
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        for (int w = 0; w < NW; w++) xfer(1'b0, AW'(w * 4), 32'h0, 4'h0, "final_rd");

        idle(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
